// File: rtl/dma_desc_sched.sv
// Descriptor scan/launch scheduler driving paired read/write DMA streamers.
// Optional DMA_ERR_STOP_EN: an AXI error stops the scan the same way an abort does.
`ifndef DMA_NUM_DESC
`define DMA_NUM_DESC 4
`endif

package dma_pkg;
  localparam int DMA_IDX_W = 8;

  typedef struct packed {
    logic        enable;
    logic [31:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic                 valid;
    logic [DMA_IDX_W-1:0] idx;
  } s_dma_str_in_t;
endpackage

module dma_desc_sched
  import dma_pkg::*;
#(
  parameter int NUM_DESC = `DMA_NUM_DESC,
  parameter int IDX_W = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  s_dma_desc_t   dma_desc_i [NUM_DESC],
  input  logic          dma_go_i,
  input  logic          dma_abort_i,
  input  logic          dma_err_i,
  output s_dma_str_in_t dma_rd_str_o,
  output s_dma_str_in_t dma_wr_str_o,
  input  logic          dma_rd_done_i,
  input  logic          dma_wr_done_i,
  output logic          dma_active_o,
  output logic          dma_done_o,
  output logic          dma_error_o,
  output logic [IDX_W-1:0] dma_err_idx_o
);

  typedef enum logic [2:0] {
    IDLE, SEL, LAUNCH, RUN, DRAIN, DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [IDX_W-1:0] cur_idx;
  logic rd_seen;
  logic wr_seen;
  logic err_stop;
  logic stop;
  logic last;
  logic desc_ok;
  logic rd_all;
  logic wr_all;
  logic both;
  logic start;

`ifdef DMA_ERR_STOP_EN
  assign err_stop = dma_err_i;
`else
  assign err_stop = 1'b0;
`endif

  assign stop    = dma_abort_i | err_stop;
  assign last    = (cur_idx == IDX_W'(NUM_DESC - 1));
  assign desc_ok = dma_desc_i[cur_idx].enable
                 & (|dma_desc_i[cur_idx].num_bytes);
  // Same-cycle done pulses count together with earlier ones.
  assign rd_all  = rd_seen | dma_rd_done_i;
  assign wr_all  = wr_seen | dma_wr_done_i;
  assign both    = rd_all & wr_all;
  assign start   = (state == IDLE) & dma_go_i & ~dma_abort_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (start) nxt = SEL;
      SEL: begin
        if (stop)         nxt = DONE;
        else if (desc_ok) nxt = LAUNCH;
        else if (last)    nxt = DONE;
      end
      LAUNCH: nxt = stop ? DONE : RUN;
      RUN: begin
        if (stop)      nxt = DRAIN;
        else if (both) nxt = last ? DONE : SEL;
      end
      DRAIN:  if (both) nxt = DONE;
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    dma_active_o       = (state != IDLE);
    dma_done_o         = (state == DONE);
    dma_rd_str_o.valid = (state == LAUNCH) & ~stop;
    dma_rd_str_o.idx   = DMA_IDX_W'(cur_idx);
    dma_wr_str_o.valid = dma_rd_str_o.valid;
    dma_wr_str_o.idx   = DMA_IDX_W'(cur_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_idx <= '0;
    end else if (start) begin
      cur_idx <= '0;
    end else if (state == SEL && !stop && !desc_ok && !last) begin
      cur_idx <= cur_idx + IDX_W'(1);
    end else if (state == RUN && !stop && both && !last) begin
      cur_idx <= cur_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_seen <= 1'b0;
      wr_seen <= 1'b0;
    end else if ((state == RUN && !stop && both)
              || (state == DRAIN && both)) begin
      rd_seen <= 1'b0;
      wr_seen <= 1'b0;
    end else if (state == RUN || state == DRAIN) begin
      rd_seen <= rd_all;
      wr_seen <= wr_all;
    end else begin
      rd_seen <= 1'b0;
      wr_seen <= 1'b0;
    end
  end

  // Only the first error of a run records its descriptor index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dma_error_o   <= 1'b0;
      dma_err_idx_o <= '0;
    end else if (start) begin
      dma_error_o   <= 1'b0;
      dma_err_idx_o <= '0;
    end else if (dma_err_i && dma_active_o && !dma_error_o) begin
      dma_error_o   <= 1'b1;
      dma_err_idx_o <= cur_idx;
    end
  end

endmodule
